// File: rtl/riscv_pkg.sv
// Shared decode definitions: opcodes, ex_ctl layout, alu_op encodings, ID/EX metadata.
// The opcode decode helper is used by the decode stage to classify instructions.
package riscv_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam int OPC_W    = 7;
  localparam int CTL_W    = 8;
  localparam int FUNCT_W  = 4;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  // Bit positions inside ex_ctl
  localparam int CTL_REG_WRITE  = 7;
  localparam int CTL_MEM_READ   = 6;
  localparam int CTL_MEM_WRITE  = 5;
  localparam int CTL_BRANCH     = 4;
  localparam int CTL_ALU_SRC    = 3;
  localparam int CTL_MEM_TO_REG = 2;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_I    = 2'b01,
    IMM_S    = 2'b10,
    IMM_B    = 2'b11
  } imm_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    mem_to_reg;
    alu_op_e alu_op;
  } ctl_t;

  typedef struct packed {
    logic     supported;
    ctl_t     ctl;
    imm_sel_e imm_sel;
  } dec_t;

  typedef struct packed {
    ctl_t               ctl;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
  } idex_meta_t;

  function automatic dec_t decode_opcode(input logic [OPC_W-1:0] opc);
    dec_t d;
    d = '0;
    d.supported = 1'b1;
    case (opc)
      OPC_R: begin
        d.ctl.reg_write = 1'b1;
        d.ctl.alu_op    = ALU_RFUNCT;
        d.imm_sel       = IMM_NONE;
      end
      OPC_I: begin
        d.ctl.reg_write = 1'b1;
        d.ctl.alu_src   = 1'b1;
        d.ctl.alu_op    = ALU_IFUNCT;
        d.imm_sel       = IMM_I;
      end
      OPC_LOAD: begin
        d.ctl.reg_write  = 1'b1;
        d.ctl.mem_read   = 1'b1;
        d.ctl.alu_src    = 1'b1;
        d.ctl.mem_to_reg = 1'b1;
        d.ctl.alu_op     = ALU_ADD;
        d.imm_sel        = IMM_I;
      end
      OPC_STORE: begin
        d.ctl.mem_write = 1'b1;
        d.ctl.alu_src   = 1'b1;
        d.ctl.alu_op    = ALU_ADD;
        d.imm_sel       = IMM_S;
      end
      OPC_BRANCH: begin
        d.ctl.branch = 1'b1;
        d.ctl.alu_op = ALU_SUB;
        d.imm_sel    = IMM_B;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file, 32 x XLEN with x0 hardwired to zero; reads are combinational
// and see a same-cycle writeback, the single write port commits on the rising edge.
module regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [REG_W-1:0] rs1_addr,
  input  logic [REG_W-1:0] rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_hit;

  assign wr_hit = wb_en && (wb_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Bypass lets an instruction in decode see the value being retired this same cycle.
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wr_hit && (wb_rd == rs1_addr)) begin
      rs1_data = wb_data;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wr_hit && (wb_rd == rs2_addr)) begin
      rs2_data = wb_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode: regfile read, imm/control generation, load-use hazard detect; IF/ID -> ID/EX in 1 cycle.
// stall_out (combinational) holds fetch on a load-use hazard; an EX flush overrides it and bubbles ID/EX.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [OPC_W-1:0]   id_ctrl,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic [REG_W-1:0]   id_rd,
  input  logic [XLEN-1:0]    id_instr,
  input  logic [PC_W-1:0]    id_pc,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [REG_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               stall_out,
  output logic               ex_valid,
  output logic [PC_W-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [REG_W-1:0]   ex_rs1,
  output logic [REG_W-1:0]   ex_rs2,
  output logic [REG_W-1:0]   ex_rd,
  output logic [CTL_W-1:0]   ex_ctl,
  output logic [FUNCT_W-1:0] ex_funct,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  dec_t            dec;
  logic [XLEN-1:0] dec_imm;
  idex_meta_t      dec_meta;
  idex_meta_t      ex_meta;
  logic            load_in_ex;
  logic            hazard;
  logic            take;
  logic            illegal_nxt;
  logic            unused_instr;

  regfile #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .rs1_addr(id_rs1),
    .rs2_addr(id_rs2),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data)
  );

  assign dec = decode_opcode(id_ctrl);

  // Opcode and rs1 come in on their own ports; these instruction bits carry nothing else here.
  assign unused_instr = ^{id_instr[19:15], id_instr[6:0]};

  always_comb begin
    dec_imm = '0;
    case (dec.imm_sel)
      IMM_I:   dec_imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
      IMM_S:   dec_imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      IMM_B:   dec_imm = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
                          id_instr[30:25], id_instr[11:8], 1'b0};
      default: dec_imm = '0;
    endcase
  end

  always_comb begin
    dec_meta       = '0;
    dec_meta.ctl   = dec.ctl;
    dec_meta.funct = {id_instr[30], id_instr[14:12]};
    dec_meta.rs1   = id_rs1;
    dec_meta.rs2   = id_rs2;
    dec_meta.rd    = id_rd;
  end

  // Load-use: the load in EX has no data until after MEM, so its consumer must wait a cycle.
  assign load_in_ex  = ex_valid && ex_meta.ctl.mem_read && (ex_meta.rd != '0);
  assign hazard      = load_in_ex && id_valid &&
                       ((ex_meta.rd == id_rs1) || (ex_meta.rd == id_rs2));
  assign stall_out   = hazard && !flush;
  assign take        = id_valid && dec.supported && !flush && !hazard;
  assign illegal_nxt = id_valid && !dec.supported && !flush && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_meta     <= '0;
    end else if (take) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= dec_imm;
      ex_meta     <= dec_meta;
    end else begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_meta     <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else begin
      illegal <= illegal_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_out && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_ctl   = ex_meta.ctl;
  assign ex_funct = ex_meta.funct;
  assign ex_rs1   = ex_meta.rs1;
  assign ex_rs2   = ex_meta.rs2;
  assign ex_rd    = ex_meta.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a reference model.
module tb_decode_stage;

  localparam int PC_W  = 8;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  localparam logic [31:0] INS_ADDI = 32'hFFF28313; // addi x6,x5,-1
  localparam logic [31:0] INS_LW   = 32'h0000A383; // lw x7,0(x1)
  localparam logic [31:0] INS_ADD  = 32'h00238433; // add x8,x7,x2
  localparam logic [31:0] INS_RD3  = 32'h00018493; // addi x9,x3,0
  localparam logic [31:0] INS_RD0  = 32'h00000513; // addi x10,x0,0
  localparam logic [31:0] INS_BEQ  = 32'hFE208CE3; // beq x1,x2,-8
  localparam logic [31:0] INS_BAD  = 32'h0000007F;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [6:0]       id_ctrl;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]  id_instr;
  logic [PC_W-1:0]  id_pc;
  logic             flush;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             stall_out;
  logic             ex_valid;
  logic [PC_W-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [7:0]       ex_ctl;
  logic [3:0]       ex_funct;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;

  decode_stage #(.PC_W(PC_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_instr(id_instr),
    .id_pc(id_pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctl(ex_ctl),
    .ex_funct(ex_funct), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural registers and the instruction expected in EX.
  logic [31:0] m_regs [32];
  logic        m_valid, m_is_load, m_ill;
  logic [7:0]  m_pc, m_ctl;
  logic [31:0] m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_funct;
  int          m_cnt;
  logic        last_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] spec_ctl(input logic [6:0] opc);
    case (opc)
      7'b0110011: return 8'h82;
      7'b0010011: return 8'h8B;
      7'b0000011: return 8'hCC;
      7'b0100011: return 8'h28;
      7'b1100011: return 8'h11;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] spec_imm(input logic [31:0] ins);
    int s;
    int v;
    s = $signed(ins);
    v = 0;
    case (ins[6:0])
      7'b0010011, 7'b0000011: v = s >>> 20;
      7'b0100011: v = (s >>> 25) * 32 + int'(ins[11:7]);
      7'b1100011: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                      + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      default:    v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 0; m_is_load = 0; m_ill = 0; m_pc = 0; m_ctl = 0;
    m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_funct = 0; m_cnt = 0; last_stall = 0;
  endtask

  task automatic model_step(input logic hz);
    logic [7:0] c;
    logic [31:0] r1, r2;
    c  = spec_ctl(id_ctrl);
    r1 = model_read(id_rs1);
    r2 = model_read(id_rs2);
    m_ill = id_valid && !flush && !hz && (c == 8'h00);
    if (hz && !flush && m_cnt < 65535) m_cnt++;
    if (id_valid && c != 8'h00 && !flush && !hz) begin
      m_valid = 1; m_pc = id_pc; m_rs1d = r1; m_rs2d = r2;
      m_imm = spec_imm(id_instr); m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_ctl = c; m_funct = {id_instr[30], id_instr[14:12]};
      m_is_load = (id_ctrl == 7'b0000011);
    end else begin
      m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctl = 0; m_funct = 0; m_is_load = 0;
    end
    if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
  endtask

  task automatic check_outputs();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rs1_data", ex_rs1_data, m_rs1d);
    chk("ex_rs2_data", ex_rs2_data, m_rs2d);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_rs1", ex_rs1, m_rs1);
    chk("ex_rs2", ex_rs2, m_rs2);
    chk("ex_rd", ex_rd, m_rd);
    chk("ex_ctl", ex_ctl, m_ctl);
    chk("ex_funct", ex_funct, m_funct);
    chk("illegal", illegal, m_ill);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic cycle();
    logic hz;
    #1;
    hz = m_valid && m_is_load && (m_rd != 0) && (m_rd == id_rs1 || m_rd == id_rs2) && id_valid;
    chk("stall_out", stall_out, hz && !flush);
    last_stall = hz && !flush;
    model_step(hz);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [31:0] ins, input logic [7:0] pc);
    id_valid = v; id_instr = ins; id_ctrl = ins[6:0];
    id_rs1 = ins[19:15]; id_rs2 = ins[24:20]; id_rd = ins[11:7]; id_pc = pc;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_en = en; wb_rd = rd; wb_data = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  logic [31:0] ins;
  logic [6:0]  opc;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_instr(1'b0, 32'h0, 8'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_stall", stall_out, 1'b0);
    check_outputs();
    @(negedge clk);

    // Writeback then addi reading it
    set_wb(1'b1, 5'd5, 32'h1234);
    cycle();
    set_wb(1'b0, 5'd0, 32'h0);
    set_instr(1'b1, INS_ADDI, 8'h04);
    cycle();
    chk("t1_rs1_data", ex_rs1_data, 32'h1234);
    chk("t1_imm", ex_imm, 32'hFFFFFFFF);
    chk("t1_ctl", ex_ctl, 8'h8B);
    chk("t1_rd", ex_rd, 5'd6);

    // Load-use back-to-back
    set_instr(1'b1, INS_LW, 8'h10);
    cycle();
    set_instr(1'b1, INS_ADD, 8'h14);
    #1 chk("t2_stall", stall_out, 1'b1);
    cycle();
    chk("t2_bubble", ex_valid, 1'b0);
    chk("t2_cnt", stall_cnt, 16'd1);
    #1 chk("t2_nostall", stall_out, 1'b0);
    cycle();
    chk("t2_issue", ex_valid, 1'b1);
    chk("t2_issue_rd", ex_rd, 5'd8);
    chk("t2_issue_ctl", ex_ctl, 8'h82);

    // Flush coincident with a load-use hazard
    set_instr(1'b1, INS_LW, 8'h20);
    cycle();
    set_instr(1'b1, INS_ADD, 8'h24);
    flush = 1'b1;
    #1 chk("t3_stall", stall_out, 1'b0);
    cycle();
    chk("t3_bubble", ex_valid, 1'b0);
    chk("t3_cnt", stall_cnt, 16'd1);
    flush = 1'b0;

    // Same-cycle writeback bypass, and x0 stays zero
    set_wb(1'b1, 5'd3, 32'hA5A5A5A5);
    set_instr(1'b1, INS_RD3, 8'h30);
    cycle();
    chk("t4_bypass", ex_rs1_data, 32'hA5A5A5A5);
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    set_instr(1'b1, INS_RD0, 8'h34);
    cycle();
    chk("t4_x0_bypass", ex_rs1_data, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    cycle();
    chk("t4_x0_read", ex_rs1_data, 32'h0);

    // Illegal opcode, then a negative branch offset
    set_instr(1'b1, INS_BAD, 8'h40);
    cycle();
    chk("t5_illegal", illegal, 1'b1);
    chk("t5_bubble", ex_valid, 1'b0);
    set_instr(1'b1, INS_BEQ, 8'h44);
    cycle();
    chk("t5_illegal_drop", illegal, 1'b0);
    chk("t5_beq_imm", ex_imm, 32'hFFFFFFF8);
    chk("t5_beq_ctl", ex_ctl, 8'h11);

    // Asynchronous reset in the middle of a stall
    set_instr(1'b1, INS_LW, 8'h50);
    cycle();
    set_instr(1'b1, INS_ADD, 8'h54);
    #1 chk("t6_stall_pre", stall_out, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_stall", stall_out, 1'b0);
    chk("t6_valid", ex_valid, 1'b0);
    chk("t6_ctl", ex_ctl, 8'h0);
    chk("t6_rd", ex_rd, 5'd0);
    chk("t6_cnt", stall_cnt, 16'd0);
    chk("t6_illegal", illegal, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_instr(1'b1, INS_ADDI, 8'h60);
    cycle();
    chk("t6_reg_cleared", ex_rs1_data, 32'h0);
    chk("t6_valid_after", ex_valid, 1'b1);

    // Randomized traffic; IF/ID holds its instruction while stalled
    for (int i = 0; i < 1500; i++) begin
      if (!last_stall) begin
        case ($urandom_range(0, 5))
          0:       opc = 7'b0110011;
          1:       opc = 7'b0010011;
          2:       opc = 7'b0000011;
          3:       opc = 7'b0100011;
          4:       opc = 7'b1100011;
          default: opc = 7'($urandom);
        endcase
        ins = $urandom;
        ins[6:0]   = opc;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        set_instr(($urandom_range(0, 7) != 0), ins, 8'($urandom));
      end
      flush = ($urandom_range(0, 7) == 0);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
